manage_hp_multi: RTL and testbench
==================================

MANAGE_HP_MULTI -- requirements
Module: manage_hp_multi

Interface
REQ-001 SHALL have parameter NUM_PLAYERS, default 2, number of players (legal range 2..4).
REQ-002 SHALL have parameter HP_MAX, default 9, starting HP per player (legal range 1..15).
REQ-003 SHALL derive the constants HP_W = clog2(HP_MAX+1) and ID_W = max(1, clog2(NUM_PLAYERS)).
REQ-004 CLK  in  1  single clock; all state updates on the rising edge.
REQ-005 RST  in  1  reset, asynchronous, active-high.
REQ-006 READY_IN  in  1  start or restart request.
REQ-007 OK  in  1  question generator ready.
REQ-008 QUE  in  1  question published by the input module.
REQ-009 QUE_IN  in  1  players may now answer.
REQ-010 JUDG  in  2  judge code: 00 none, 01 solved by WIN_ID, 10 solved by other side, 11 timeout.
REQ-011 WIN_ID  in  ID_W  index of the solving player; valid when JUDG=01 or JUDG=10.
REQ-012 WRONG_IN  in  NUM_PLAYERS  one-cycle wrong-answer pulse per player.
REQ-013 STATE  out  4  current FSM state code.
REQ-014 HP  out  NUM_PLAYERS*HP_W  packed HP values; player p occupies field p.
REQ-015 LEDR  out  NUM_PLAYERS*HP_MAX  HP bar; bit p*HP_MAX+i = (HP_p > i).
REQ-016 ALIVE  out  NUM_PLAYERS  bit p = (HP_p != 0).
REQ-017 GAME_OVER  out  1  high while STATE=OVER.

Function
REQ-018 SHALL implement states IDLE=0, WAIT=1, QUESTION=2, INPUT=3, JUDGE=4, OVER=5; codes 6..15 are unused and SHALL go to IDLE on the next edge.
REQ-019 IDLE: on READY_IN, SHALL load every HP with HP_MAX and go to WAIT.
REQ-020 WAIT: when OK and QUE are both high, SHALL go to QUESTION.
REQ-021 QUESTION: on QUE_IN, SHALL go to INPUT.
REQ-022 INPUT: when JUDG != 00, SHALL register JUDG and WIN_ID and go to JUDGE on the same edge.
REQ-023 JUDGE: SHALL last exactly one cycle and apply the registered code on the edge that leaves it.
REQ-024 JUDGE, code 01 or 10: every alive player other than WIN_ID SHALL lose 1 HP.
REQ-025 JUDGE, code 11: every alive player SHALL lose 1 HP.
REQ-026 JUDGE exit: SHALL go to OVER if the post-update alive count is <= 1, else to WAIT.
REQ-027 INPUT: a WRONG_IN[p] pulse SHALL decrement HP_p by 1 on that edge; several players may be hit on the same edge.
REQ-028 WRONG_IN SHALL be ignored outside INPUT and for dead players.
REQ-029 If JUDG != 00 and WRONG_IN arrive on the same INPUT edge, both SHALL be honoured: the wrong decrement now and the judge decrement in JUDGE.
REQ-030 INPUT: if a wrong decrement leaves the alive count <= 1, SHALL go to OVER on that edge; this takes precedence over going to JUDGE.
REQ-031 HP SHALL saturate at 0 and never wrap.
REQ-032 A WIN_ID >= NUM_PLAYERS, or naming a dead player, with code 01/10 SHALL cause no HP change.
REQ-033 OVER: SHALL hold HP frozen; on READY_IN SHALL reload HP_MAX for all players and go to WAIT.
REQ-034 LEDR, ALIVE and GAME_OVER SHALL be combinational decodes of registered HP and STATE (zero added latency).

Reset
REQ-035 On RST, SHALL immediately set STATE=IDLE, every HP=HP_MAX, and clear the registered judge code and WIN_ID.
REQ-036 After reset, LEDR SHALL be all ones, ALIVE all ones, and GAME_OVER 0.
REQ-037 RST asserted in any state, including mid-JUDGE, SHALL abort the round with no partial HP update.

Structure
REQ-038 Package manage_hp_pkg SHALL hold the state enum (4-bit) and the JUDG code constants (JUDG_NONE, JUDG_WIN, JUDG_LOSE, JUDG_TIMEOUT).
REQ-039 SHALL instantiate one sub-module hp_counter per player, providing load of HP_MAX, saturating decrement-by-1 enable and a zero flag.

Verification
REQ-040 Reset then READY_IN, OK+QUE, QUE_IN, JUDG=01 with WIN_ID=0 -> STATE sequence 0,1,2,3,4,1; HP={9,8}; LEDR[17:9] = 0_1111_1111.
REQ-041 NUM_PLAYERS=2, HP_MAX=1, JUDG=11 -> both HP=0, STATE=OVER, GAME_OVER=1, ALIVE=00; then READY_IN -> HP={1,1}, STATE=WAIT.
REQ-042 Same edge in INPUT with WRONG_IN=01 and JUDG=10, WIN_ID=1 -> HP0 drops by 1 on that edge and by 1 more on JUDGE exit; HP1 unchanged.
REQ-043 NUM_PLAYERS=3: wrong pulses reduce player 1 to 0, then repeated JUDG=01 rounds with WIN_ID=0 -> HP1 stays 0 (no wrap), and OVER is reached when HP2=0.
REQ-044 Assert RST while STATE=JUDGE -> STATE=0 and all HP=HP_MAX in the same cycle, with no decrement applied.

Source files
------------

// File: rtl/manage_hp_pkg.sv
// Shared types for the multi-player HP manager: FSM state encoding and judge codes.
package manage_hp_pkg;

    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_WAIT     = 4'd1,
        S_QUESTION = 4'd2,
        S_INPUT    = 4'd3,
        S_JUDGE    = 4'd4,
        S_OVER     = 4'd5
    } state_e;

    localparam logic [1:0] JUDG_NONE    = 2'b00;
    localparam logic [1:0] JUDG_WIN     = 2'b01;
    localparam logic [1:0] JUDG_LOSE    = 2'b10;
    localparam logic [1:0] JUDG_TIMEOUT = 2'b11;

endpackage

// File: rtl/hp_counter.sv
// Per-player HP register: reload to HP_MAX, saturating decrement by one, zero flag.
module hp_counter #(
    parameter int HP_MAX = 9,
    parameter int HP_W   = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load,
    input  logic            dec,
    output logic [HP_W-1:0] hp,
    output logic            zero
);

    logic [HP_W-1:0] hp_q, hp_d;

    always_comb begin
        hp_d = hp_q;
        if (load)
            hp_d = HP_W'(HP_MAX);
        else if (dec && hp_q != '0)
            hp_d = hp_q - 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            hp_q <= HP_W'(HP_MAX);
        else
            hp_q <= hp_d;
    end

    assign hp   = hp_q;
    assign zero = (hp_q == '0);

endmodule

// File: rtl/manage_hp_multi.sv
// Quiz-game HP manager: round FSM, wrong-answer and judge penalties, HP bar decode.
module manage_hp_multi
    import manage_hp_pkg::*;
#(
    parameter int NUM_PLAYERS = 2,
    parameter int HP_MAX      = 9,
    localparam int HP_W       = $clog2(HP_MAX + 1),
    localparam int ID_W       = (NUM_PLAYERS > 2) ? $clog2(NUM_PLAYERS) : 1
) (
    input  logic                          CLK,
    input  logic                          RST,
    input  logic                          READY_IN,
    input  logic                          OK,
    input  logic                          QUE,
    input  logic                          QUE_IN,
    input  logic [1:0]                    JUDG,
    input  logic [ID_W-1:0]               WIN_ID,
    input  logic [NUM_PLAYERS-1:0]        WRONG_IN,
    output logic [3:0]                    STATE,
    output logic [NUM_PLAYERS*HP_W-1:0]   HP,
    output logic [NUM_PLAYERS*HP_MAX-1:0] LEDR,
    output logic [NUM_PLAYERS-1:0]        ALIVE,
    output logic                          GAME_OVER
);

    state_e          state_q, state_d;
    logic [1:0]      judg_q, judg_d;
    logic [ID_W-1:0] win_q, win_d;

    logic [NUM_PLAYERS-1:0][HP_W-1:0] hp_arr;
    logic [NUM_PLAYERS-1:0] zero, alive, last_hp;
    logic [NUM_PLAYERS-1:0] wrong_dec, judge_dec, win_sel, dec;
    logic                   load, win_ok;
    logic                   wrong_ends, judge_ends;

    assign alive = ~zero;

    // Penalty vectors and "alive count <= 1 after this decrement" for both sources
    always_comb begin
        int wrong_left;
        int judge_left;
        wrong_dec = WRONG_IN & alive;
        win_sel   = '0;
        for (int p = 0; p < NUM_PLAYERS; p++)
            win_sel[p] = (32'(win_q) == p);
        win_ok = |(win_sel & alive);
        case (judg_q)
            JUDG_WIN, JUDG_LOSE: judge_dec = win_ok ? (alive & ~win_sel) : '0;
            JUDG_TIMEOUT:        judge_dec = alive;
            default:             judge_dec = '0;
        endcase
        wrong_left = 0;
        judge_left = 0;
        for (int p = 0; p < NUM_PLAYERS; p++) begin
            if (alive[p] && !(wrong_dec[p] && last_hp[p])) wrong_left++;
            if (alive[p] && !(judge_dec[p] && last_hp[p])) judge_left++;
        end
        wrong_ends = (wrong_dec != '0) && (wrong_left <= 1);
        judge_ends = (judge_left <= 1);
    end

    always_comb begin
        state_d = state_q;
        judg_d  = judg_q;
        win_d   = win_q;
        load    = 1'b0;
        dec     = '0;
        case (state_q)
            S_IDLE: if (READY_IN) begin
                load    = 1'b1;
                state_d = S_WAIT;
            end
            S_WAIT:     if (OK && QUE) state_d = S_QUESTION;
            S_QUESTION: if (QUE_IN)    state_d = S_INPUT;
            S_INPUT: begin
                dec = wrong_dec;
                if (JUDG != JUDG_NONE) begin
                    judg_d = JUDG;
                    win_d  = WIN_ID;
                end
                // A knockout from a wrong answer ends the game before judging
                if (wrong_ends)
                    state_d = S_OVER;
                else if (JUDG != JUDG_NONE)
                    state_d = S_JUDGE;
            end
            S_JUDGE: begin
                dec     = judge_dec;
                state_d = judge_ends ? S_OVER : S_WAIT;
            end
            S_OVER: if (READY_IN) begin
                load    = 1'b1;
                state_d = S_WAIT;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= S_IDLE;
            judg_q  <= JUDG_NONE;
            win_q   <= '0;
        end else begin
            state_q <= state_d;
            judg_q  <= judg_d;
            win_q   <= win_d;
        end
    end

    for (genvar gp = 0; gp < NUM_PLAYERS; gp++) begin : g_player
        hp_counter #(.HP_MAX(HP_MAX), .HP_W(HP_W)) u_hp (
            .clk  (CLK),
            .rst  (RST),
            .load (load),
            .dec  (dec[gp]),
            .hp   (hp_arr[gp]),
            .zero (zero[gp])
        );
        assign last_hp[gp] = (hp_arr[gp] == HP_W'(1));
        for (genvar gi = 0; gi < HP_MAX; gi++) begin : g_bar
            assign LEDR[gp*HP_MAX+gi] = (hp_arr[gp] > HP_W'(gi));
        end
    end

    assign HP        = hp_arr;
    assign STATE     = state_q;
    assign ALIVE     = alive;
    assign GAME_OVER = (state_q == S_OVER);

endmodule

// File: tb/tb_manage_hp_multi.sv
// Directed table-driven bench over three configurations: (2,9), (2,1), (3,4).
module tb_manage_hp_multi;

    typedef struct {
        int         dut;
        bit         rdy, ok, que, qin;
        logic [1:0] judg;
        logic [1:0] win;
        logic [2:0] wrong;
        int         st, h0, h1, h2;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic a_rdy, a_ok, a_que, a_qin; logic [1:0] a_judg; logic [0:0] a_win; logic [1:0] a_wrong;
    logic [3:0] a_state; logic [7:0] a_hp; logic [17:0] a_ledr; logic [1:0] a_alive; logic a_go;
    logic b_rdy, b_ok, b_que, b_qin; logic [1:0] b_judg; logic [0:0] b_win; logic [1:0] b_wrong;
    logic [3:0] b_state; logic [1:0] b_hp; logic [1:0] b_ledr; logic [1:0] b_alive; logic b_go;
    logic c_rdy, c_ok, c_que, c_qin; logic [1:0] c_judg; logic [1:0] c_win; logic [2:0] c_wrong;
    logic [3:0] c_state; logic [8:0] c_hp; logic [11:0] c_ledr; logic [2:0] c_alive; logic c_go;

    manage_hp_multi #(.NUM_PLAYERS(2), .HP_MAX(9)) u_a (
        .CLK(clk), .RST(rst), .READY_IN(a_rdy), .OK(a_ok), .QUE(a_que), .QUE_IN(a_qin),
        .JUDG(a_judg), .WIN_ID(a_win), .WRONG_IN(a_wrong), .STATE(a_state), .HP(a_hp),
        .LEDR(a_ledr), .ALIVE(a_alive), .GAME_OVER(a_go));
    manage_hp_multi #(.NUM_PLAYERS(2), .HP_MAX(1)) u_b (
        .CLK(clk), .RST(rst), .READY_IN(b_rdy), .OK(b_ok), .QUE(b_que), .QUE_IN(b_qin),
        .JUDG(b_judg), .WIN_ID(b_win), .WRONG_IN(b_wrong), .STATE(b_state), .HP(b_hp),
        .LEDR(b_ledr), .ALIVE(b_alive), .GAME_OVER(b_go));
    manage_hp_multi #(.NUM_PLAYERS(3), .HP_MAX(4)) u_c (
        .CLK(clk), .RST(rst), .READY_IN(c_rdy), .OK(c_ok), .QUE(c_que), .QUE_IN(c_qin),
        .JUDG(c_judg), .WIN_ID(c_win), .WRONG_IN(c_wrong), .STATE(c_state), .HP(c_hp),
        .LEDR(c_ledr), .ALIVE(c_alive), .GAME_OVER(c_go));

    int checks = 0;
    int errors = 0;
    vec_t vq[$];

    task automatic chk(input string nm, input int row, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s row %0d: got %0d expected %0d", nm, row, act, exp);
        end
    endtask

    task automatic add(input int d, input bit r, input bit o, input bit q, input bit qi,
                       input logic [1:0] j, input logic [1:0] w, input logic [2:0] wr,
                       input int st, input int h0, input int h1, input int h2);
        vec_t v;
        v.dut = d; v.rdy = r; v.ok = o; v.que = q; v.qin = qi;
        v.judg = j; v.win = w; v.wrong = wr;
        v.st = st; v.h0 = h0; v.h1 = h1; v.h2 = h2;
        vq.push_back(v);
    endtask

    // Expected bar/alive built from expected HP values
    task automatic check_dut(input int d, input int row, input int st, input int e0, input int e1, input int e2);
        int np, hm, s, h0, h1, h2, ledr, alv, go, el, ea;
        int hs[3];
        np = (d == 2) ? 3 : 2;
        hm = (d == 0) ? 9 : (d == 1) ? 1 : 4;
        case (d)
            0: begin s = int'(a_state); h0 = int'(a_hp[3:0]); h1 = int'(a_hp[7:4]); h2 = 0;
                     ledr = int'(a_ledr); alv = int'(a_alive); go = int'(a_go); end
            1: begin s = int'(b_state); h0 = int'(b_hp[0]); h1 = int'(b_hp[1]); h2 = 0;
                     ledr = int'(b_ledr); alv = int'(b_alive); go = int'(b_go); end
            default: begin s = int'(c_state); h0 = int'(c_hp[2:0]); h1 = int'(c_hp[5:3]);
                     h2 = int'(c_hp[8:6]); ledr = int'(c_ledr); alv = int'(c_alive); go = int'(c_go); end
        endcase
        hs[0] = e0; hs[1] = e1; hs[2] = e2;
        el = 0; ea = 0;
        for (int p = 0; p < np; p++) begin
            if (hs[p] != 0) ea |= (1 << p);
            for (int i = 0; i < hm; i++)
                if (hs[p] > i) el |= (1 << (p*hm + i));
        end
        chk($sformatf("state_d%0d", d), row, s, st);
        chk($sformatf("hp0_d%0d", d), row, h0, e0);
        chk($sformatf("hp1_d%0d", d), row, h1, e1);
        if (d == 2) chk("hp2_d2", row, h2, e2);
        chk($sformatf("ledr_d%0d", d), row, ledr, el);
        chk($sformatf("alive_d%0d", d), row, alv, ea);
        chk($sformatf("gameover_d%0d", d), row, go, (st == 5) ? 1 : 0);
    endtask

    task automatic clear_inputs();
        a_rdy = 0; a_ok = 0; a_que = 0; a_qin = 0; a_judg = 0; a_win = 0; a_wrong = 0;
        b_rdy = 0; b_ok = 0; b_que = 0; b_qin = 0; b_judg = 0; b_win = 0; b_wrong = 0;
        c_rdy = 0; c_ok = 0; c_que = 0; c_qin = 0; c_judg = 0; c_win = 0; c_wrong = 0;
    endtask

    task automatic run_row(input vec_t v, input int row);
        clear_inputs();
        case (v.dut)
            0: begin a_rdy = v.rdy; a_ok = v.ok; a_que = v.que; a_qin = v.qin;
                     a_judg = v.judg; a_win = v.win[0:0]; a_wrong = v.wrong[1:0]; end
            1: begin b_rdy = v.rdy; b_ok = v.ok; b_que = v.que; b_qin = v.qin;
                     b_judg = v.judg; b_win = v.win[0:0]; b_wrong = v.wrong[1:0]; end
            default: begin c_rdy = v.rdy; c_ok = v.ok; c_que = v.que; c_qin = v.qin;
                     c_judg = v.judg; c_win = v.win; c_wrong = v.wrong; end
        endcase
        @(posedge clk); #1;
        check_dut(v.dut, row, v.st, v.h0, v.h1, v.h2);
    endtask

    task automatic round(input int d, input logic [1:0] j, input logic [1:0] w,
                         input int st, input int h0, input int h1, input int h2,
                         input int p0, input int p1, input int p2);
        add(d, 0,1,1,0, 0,0,0, 2, p0,p1,p2);
        add(d, 0,0,0,1, 0,0,0, 3, p0,p1,p2);
        add(d, 0,0,0,0, j,w,0, 4, p0,p1,p2);
        add(d, 0,0,0,0, 0,0,0, st, h0,h1,h2);
    endtask

    initial begin
        rst = 1'b1;
        clear_inputs();
        repeat (2) @(posedge clk);
        #1;
        check_dut(0, -1, 0, 9, 9, 0);
        check_dut(1, -1, 0, 1, 1, 0);
        check_dut(2, -1, 0, 4, 4, 4);
        rst = 1'b0;

        // DUT A: 2 players, HP_MAX=9
        add(0, 1,0,0,0, 0,0,0, 1, 9,9,0);
        round(0, 2'b01, 0, 1, 9,8,0, 9,9,0);
        add(0, 0,1,0,0, 0,0,0, 1, 9,8,0);
        add(0, 0,0,1,0, 0,0,0, 1, 9,8,0);
        add(0, 0,1,1,0, 0,0,0, 2, 9,8,0);
        add(0, 0,0,0,0, 0,0,3'b011, 2, 9,8,0);
        add(0, 0,0,0,1, 0,0,0, 3, 9,8,0);
        add(0, 0,0,0,0, 2'b10,1,3'b001, 4, 8,8,0);
        add(0, 0,0,0,0, 0,0,0, 1, 7,8,0);
        add(0, 0,1,1,0, 0,0,0, 2, 7,8,0);
        add(0, 0,0,0,1, 0,0,0, 3, 7,8,0);
        add(0, 0,0,0,0, 0,0,3'b010, 3, 7,7,0);
        add(0, 0,0,0,0, 2'b11,0,0, 4, 7,7,0);
        add(0, 0,0,0,0, 0,0,0, 1, 6,6,0);
        add(0, 1,0,0,0, 0,0,0, 1, 6,6,0);

        // DUT B: 2 players, HP_MAX=1
        add(1, 1,0,0,0, 0,0,0, 1, 1,1,0);
        round(1, 2'b11, 0, 5, 0,0,0, 1,1,0);
        add(1, 0,0,0,0, 0,0,3'b011, 5, 0,0,0);
        add(1, 1,0,0,0, 0,0,0, 1, 1,1,0);
        add(1, 0,1,1,0, 0,0,0, 2, 1,1,0);
        add(1, 0,0,0,1, 0,0,0, 3, 1,1,0);
        add(1, 0,0,0,0, 2'b01,1,3'b001, 5, 0,1,0);
        add(1, 0,0,0,0, 0,0,0, 5, 0,1,0);
        add(1, 1,0,0,0, 0,0,0, 1, 1,1,0);
        round(1, 2'b01, 0, 5, 1,0,0, 1,1,0);

        // DUT C: 3 players, HP_MAX=4
        add(2, 1,0,0,0, 0,0,0, 1, 4,4,4);
        add(2, 0,1,1,0, 0,0,0, 2, 4,4,4);
        add(2, 0,0,0,1, 0,0,0, 3, 4,4,4);
        add(2, 0,0,0,0, 0,0,3'b010, 3, 4,3,4);
        add(2, 0,0,0,0, 0,0,3'b010, 3, 4,2,4);
        add(2, 0,0,0,0, 0,0,3'b010, 3, 4,1,4);
        add(2, 0,0,0,0, 0,0,3'b010, 3, 4,0,4);
        add(2, 0,0,0,0, 0,0,3'b010, 3, 4,0,4);
        add(2, 0,0,0,0, 2'b01,0,0, 4, 4,0,4);
        add(2, 0,0,0,0, 0,0,0, 1, 4,0,3);
        round(2, 2'b01, 3, 1, 4,0,3, 4,0,3);
        round(2, 2'b01, 1, 1, 4,0,3, 4,0,3);
        round(2, 2'b01, 0, 1, 4,0,2, 4,0,3);
        round(2, 2'b11, 0, 1, 3,0,1, 4,0,2);
        round(2, 2'b10, 2, 1, 2,0,1, 3,0,1);
        round(2, 2'b01, 0, 5, 2,0,0, 2,0,1);
        add(2, 0,0,0,0, 0,0,3'b111, 5, 2,0,0);
        add(2, 1,0,0,0, 0,0,0, 1, 4,4,4);

        // DUT A walked into JUDGE for the reset-abort sequence below
        add(0, 0,1,1,0, 0,0,0, 2, 6,6,0);
        add(0, 0,0,0,1, 0,0,0, 3, 6,6,0);
        add(0, 0,0,0,0, 2'b11,0,0, 4, 6,6,0);

        for (int r = 0; r < vq.size(); r++)
            run_row(vq[r], r);

        // Reset mid-JUDGE: immediate return to IDLE with full HP, no decrement later
        clear_inputs();
        #1 rst = 1'b1;
        #1;
        check_dut(0, 900, 0, 9, 9, 0);
        check_dut(2, 900, 0, 4, 4, 4);
        #1 rst = 1'b0;
        @(posedge clk); #1;
        check_dut(0, 901, 0, 9, 9, 0);
        @(posedge clk); #1;
        check_dut(0, 902, 0, 9, 9, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
